// File: rtl/tmds_decoder.sv
// One TMDS sink channel. Finds the 10-bit symbol boundary in an unaligned
// deserialized word stream by hunting for runs of control tokens, then
// decodes aligned symbols into pixel data, control value and data enable.
module tmds_decoder #(
  parameter int CTRL_RUN = 8,     // identical-offset tokens needed to lock (>= 2)
  parameter int DWELL    = 4096,  // search cycles spent at one offset
  parameter int TIMEOUT  = 4096   // token-free cycles tolerated while locked
) (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic [9:0] din,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
);

  localparam int RUN_W = (CTRL_RUN > 2) ? $clog2(CTRL_RUN) : 1;
  localparam int DW_W  = (DWELL    > 2) ? $clog2(DWELL)    : 1;
  localparam int TO_W  = (TIMEOUT  > 2) ? $clog2(TIMEOUT)  : 1;

  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL - 1);
  localparam logic [TO_W-1:0]  IDLE_MAX  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t            state;
  logic [9:0]        din_q;
  logic [19:0]       window;
  logic [9:0]        sym_next;
  logic [9:0]        sym;
  logic              tok_hit;
  logic [1:0]        tok_val;
  logic [7:0]        m_bits;
  logic [7:0]        dec;
  logic [RUN_W-1:0]  run_cnt;
  logic [DW_W-1:0]   dwell_cnt;
  logic [TO_W-1:0]   idle_cnt;

  // Offsets step 0..9 and wrap.
  function automatic logic [3:0] next_offset(input logic [3:0] o);
    return (o == 4'd9) ? 4'd0 : o + 4'd1;
  endfunction

  // Older word in the low half: bit 0 of the window is the earliest bit seen.
  assign window = {din, din_q};

  // Keep the previous word so a symbol straddling two words can be sliced out.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) din_q <= '0;
    else        din_q <= din;
  end

  // Select the 10-bit symbol at the current alignment offset.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sym_next = window[9:0];
    for (int k = 1; k < 10; k++) begin
      if (offset == 4'(k)) sym_next = window[k +: 10];
    end
  end

  // Stage 1: register the aligned symbol.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) sym <= '0;
    else        sym <= sym_next;
  end

  // Classify the stage-1 symbol as one of the four control tokens.
  always_comb begin
    tok_hit = 1'b1;
    tok_val = 2'b00;
    case (sym)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: tok_hit = 1'b0;
    endcase
  end

  // Undo DC balancing (bit 9) and XOR/XNOR transition coding (bit 8).
  always_comb begin
    m_bits = sym[9] ? ~sym[7:0] : sym[7:0];
    dec    = '0;
    dec[0] = m_bits[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym[8] ? (m_bits[i] ^ m_bits[i-1]) : ~(m_bits[i] ^ m_bits[i-1]);
    end
  end

  // Alignment FSM plus stage-2 output register; outputs follow the state being
  // entered so de/data never disagree with locked.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      offset    <= '0;
      run_cnt   <= '0;
      dwell_cnt <= '0;
      idle_cnt  <= '0;
      locked    <= 1'b0;
      de        <= 1'b0;
      data      <= '0;
      ctrl      <= '0;
    end else begin
      case (state)
        SEARCH: begin
          locked <= 1'b0;
          de     <= 1'b0;
          data   <= '0;
          ctrl   <= '0;
          if (tok_hit) begin
            // A token found on the very cycle dwell expires keeps this offset.
            state     <= VERIFY;
            run_cnt   <= RUN_W'(1);
            dwell_cnt <= '0;
          end else if (dwell_cnt == DWELL_MAX) begin
            offset    <= next_offset(offset);
            dwell_cnt <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end

        VERIFY: begin
          if (tok_hit) begin
            if (run_cnt == RUN_LAST) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              idle_cnt <= '0;
              ctrl     <= tok_val;
              de       <= 1'b0;
              data     <= '0;
            end else begin
              run_cnt <= run_cnt + 1'b1;
            end
          end else begin
            // Run broken: this offset is wrong, try the next one.
            state     <= SEARCH;
            offset    <= next_offset(offset);
            dwell_cnt <= '0;
          end
        end

        LOCKED: begin
          if (tok_hit) begin
            idle_cnt <= '0;
            ctrl     <= tok_val;
            de       <= 1'b0;
            data     <= '0;
          end else if (idle_cnt == IDLE_MAX) begin
            // No blanking seen for too long; re-search starting at this offset.
            state     <= SEARCH;
            locked    <= 1'b0;
            dwell_cnt <= '0;
            de        <= 1'b0;
            data      <= '0;
            ctrl      <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
            de       <= 1'b1;
            data     <= dec;
          end
        end

        default: state <= SEARCH;
      endcase
    end
  end

endmodule
